// File: rtl/game_sequencer.sv
// Round sequencer for a target game: button sync, countdown, timed play and spawn pacing.
// Define GAME_SEQ_PAUSE_EN to build the pause button path and the PAUSED state.
module game_sequencer #(
  parameter int unsigned CLK_HZ            = 50_000_000,
  parameter int unsigned ROUND_SECONDS     = 60,
  parameter int unsigned COUNTDOWN_SECONDS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_n,
  input  logic        pause_n,
  input  logic [1:0]  speed_level,
  input  logic        hit_pulse,
  input  logic [13:0] score,
  output logic [2:0]  state,
  output logic        play_en,
  output logic [5:0]  timer,
  output logic [1:0]  countdown,
  output logic        sec_tick,
  output logic        spawn_tick,
  output logic        round_done,
  output logic [13:0] high_score
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SW = $clog2(2 * CLK_HZ);

  localparam logic [PW-1:0] PrescLast    = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SpawnLastSlow = SW'(2 * CLK_HZ - 1);
  localparam logic [SW-1:0] SpawnLastMid  = SW'((3 * CLK_HZ) / 2 - 1);
  localparam logic [SW-1:0] SpawnLastFast = SW'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StPaused    = 3'd3,
    StOver      = 3'd4
  } state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic [1:0]    r_start_sync;
  logic          r_start_prev;
  logic          r_start_press;
  logic          w_pause_press;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_countdown;
  logic [5:0]    r_timer;
  logic [SW-1:0] r_spawn_cnt;
  logic [1:0]    r_speed;
  logic          r_spawn_tick;
  logic          r_round_done;
  logic [13:0]   r_high_score;

  logic          w_sec_tick;
  logic [SW-1:0] w_spawn_last;
  logic          w_spawn_expire;
  logic          w_start_round;
  logic          w_enter_play;
  logic          w_stay_play;
  logic          w_enter_over;
  logic          w_spawn_evt;

  // 2-flop sync, falling-edge detect, registered press: state moves on the 4th edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_sync  <= 2'b11;
      r_start_prev  <= 1'b1;
      r_start_press <= 1'b0;
    end else begin
      r_start_sync  <= {r_start_sync[0], start_n};
      r_start_prev  <= r_start_sync[1];
      r_start_press <= r_start_prev & ~r_start_sync[1];
    end
  end

`ifdef GAME_SEQ_PAUSE_EN
  logic [1:0] r_pause_sync;
  logic       r_pause_prev;
  logic       r_pause_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause_sync  <= 2'b11;
      r_pause_prev  <= 1'b1;
      r_pause_press <= 1'b0;
    end else begin
      r_pause_sync  <= {r_pause_sync[0], pause_n};
      r_pause_prev  <= r_pause_sync[1];
      r_pause_press <= r_pause_prev & ~r_pause_sync[1];
    end
  end

  assign w_pause_press = r_pause_press;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_n;
  assign w_pause_press  = 1'b0;
`endif

  assign w_sec_tick = ((r_state == StCountdown) || (r_state == StPlay)) && (r_presc == PrescLast);

  always_comb begin
    case (r_speed)
      2'b00:   w_spawn_last = SpawnLastSlow;
      2'b01:   w_spawn_last = SpawnLastMid;
      default: w_spawn_last = SpawnLastFast;
    endcase
  end

  assign w_spawn_expire = (r_spawn_cnt >= w_spawn_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Timer expiry outranks a simultaneous pause press.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StOver: begin
        if (r_start_press) w_state_next = StCountdown;
      end
      StCountdown: begin
        if (w_sec_tick && (r_countdown == 2'd1)) w_state_next = StPlay;
      end
      StPlay: begin
        if (w_sec_tick && (r_timer == 6'd1)) w_state_next = StOver;
        else if (w_pause_press)              w_state_next = StPaused;
      end
      StPaused: begin
        if (r_start_press)      w_state_next = StIdle;
        else if (w_pause_press) w_state_next = StPlay;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_start_round = ((r_state == StIdle) || (r_state == StOver)) &&
                         (w_state_next == StCountdown);
  assign w_enter_play  = (r_state == StCountdown) && (w_state_next == StPlay);
  assign w_stay_play   = (r_state == StPlay) && (w_state_next == StPlay);
  assign w_enter_over  = (r_state == StPlay) && (w_state_next == StOver);
  // Hit and expiry in the same cycle merge into one event; nothing spawns on the way out of PLAY.
  assign w_spawn_evt   = w_enter_play | (w_stay_play & (hit_pulse | w_spawn_expire));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        StCountdown, StPlay: r_presc <= w_sec_tick ? '0 : r_presc + PW'(1);
        StPaused:            if (w_state_next == StIdle) r_presc <= '0;
        default:             r_presc <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_countdown <= 2'd0;
      r_timer     <= 6'(ROUND_SECONDS);
    end else begin
      if (w_start_round) begin
        r_countdown <= 2'(COUNTDOWN_SECONDS);
        r_timer     <= 6'(ROUND_SECONDS);
      end else begin
        if ((r_state == StCountdown) && w_sec_tick && (r_countdown != 2'd0)) begin
          r_countdown <= r_countdown - 2'd1;
        end
        if ((r_state == StPlay) && w_sec_tick && (r_timer != 6'd0)) begin
          r_timer <= r_timer - 6'd1;
        end
      end
    end
  end

  // On the way into PAUSED an expiring count is held so its spawn fires right after resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spawn_cnt <= '0;
    end else if (w_stay_play) begin
      r_spawn_cnt <= w_spawn_evt ? '0 : r_spawn_cnt + SW'(1);
    end else if ((r_state == StPlay) && (w_state_next == StPaused)) begin
      r_spawn_cnt <= w_spawn_expire ? r_spawn_cnt : r_spawn_cnt + SW'(1);
    end else if ((r_state != StPaused) || (w_state_next == StIdle)) begin
      r_spawn_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed      <= 2'b00;
      r_spawn_tick <= 1'b0;
      r_round_done <= 1'b0;
      r_high_score <= 14'd0;
    end else begin
      if (w_spawn_evt) r_speed <= speed_level;
      r_spawn_tick <= w_spawn_evt;
      r_round_done <= w_enter_over;
      if (w_enter_over && (score > r_high_score)) r_high_score <= score;
    end
  end

  always_comb begin
    state      = r_state;
    play_en    = (r_state == StPlay);
    timer      = r_timer;
    countdown  = r_countdown;
    sec_tick   = w_sec_tick;
    spawn_tick = r_spawn_tick;
    round_done = r_round_done;
    high_score = r_high_score;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer at CLK_HZ=10, 5 s rounds, 3 s countdown. Spawn and
// round_done pulses are scored against predicted cycle numbers held in queues.
module tb_game_sequencer;

  localparam int unsigned CLK_HZ  = 10;
  localparam int unsigned ROUND_S = 5;
  localparam int unsigned CD_S    = 3;
`ifdef GAME_SEQ_PAUSE_EN
  localparam int PauseShift = 100;
`else
  localparam int PauseShift = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_n;
  logic        pause_n;
  logic [1:0]  speed_level;
  logic        hit_pulse;
  logic [13:0] score;
  logic [2:0]  state;
  logic        play_en;
  logic [5:0]  timer;
  logic [1:0]  countdown;
  logic        sec_tick;
  logic        spawn_tick;
  logic        round_done;
  logic [13:0] high_score;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int spawn_q[$];
  int done_q[$];

  game_sequencer #(
    .CLK_HZ            (CLK_HZ),
    .ROUND_SECONDS     (ROUND_S),
    .COUNTDOWN_SECONDS (CD_S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_n     (start_n),
    .pause_n     (pause_n),
    .speed_level (speed_level),
    .hit_pulse   (hit_pulse),
    .score       (score),
    .state       (state),
    .play_en     (play_en),
    .timer       (timer),
    .countdown   (countdown),
    .sec_tick    (sec_tick),
    .spawn_tick  (spawn_tick),
    .round_done  (round_done),
    .high_score  (high_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_play_en"}, play_en, 0);
    chk({tag, "_timer"}, timer, ROUND_S);
    chk({tag, "_countdown"}, countdown, 0);
    chk({tag, "_sec_tick"}, sec_tick, 0);
    chk({tag, "_spawn_tick"}, spawn_tick, 0);
    chk({tag, "_round_done"}, round_done, 0);
    chk({tag, "_high_score"}, high_score, 0);
  endtask

  // Every observed pulse must match the earliest outstanding prediction.
  always @(negedge clk) begin : monitor
    int exp_c;
    if (spawn_tick) begin
      exp_c = -1;
      if (spawn_q.size() != 0) exp_c = spawn_q.pop_front();
      checks++;
      assert (cyc === exp_c) else begin
        errors++;
        $error("FAIL spawn_tick_cycle observed=%0d expected=%0d", cyc, exp_c);
      end
    end
    if (round_done) begin
      exp_c = -1;
      if (done_q.size() != 0) exp_c = done_q.pop_front();
      checks++;
      assert (cyc === exp_c) else begin
        errors++;
        $error("FAIL round_done_cycle observed=%0d expected=%0d", cyc, exp_c);
      end
    end
  end

  initial begin
    int s;
    int e;
    rst_n       = 1'b0;
    start_n     = 1'b1;
    pause_n     = 1'b1;
    hit_pulse   = 1'b0;
    speed_level = 2'b00;
    score       = 14'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    at_cyc(cyc + 2);
    chk("idle_after_reset", state, 0);

    // Round 1: countdown timing, speed change mid-interval, score 42 sets the high score.
    s = cyc;
    e = s + 34;
    score   = 14'd42;
    start_n = 1'b0;
    spawn_q.push_back(e);
    spawn_q.push_back(e + 20);
    spawn_q.push_back(e + 30);
    spawn_q.push_back(e + 40);
    done_q.push_back(e + 50);
    at_cyc(s + 3);  chk("press_edge3_state", state, 0);
    at_cyc(s + 4);  chk("press_edge4_state", state, 1);
                    chk("cd_load", countdown, 3);
                    chk("timer_load", timer, 5);
    at_cyc(s + 6);  start_n = 1'b1;
    at_cyc(s + 12); chk("sec_tick_low", sec_tick, 0);
    at_cyc(s + 13); chk("cd_hold3", countdown, 3);
                    chk("sec_tick_first", sec_tick, 1);
    at_cyc(s + 14); chk("cd_2", countdown, 2);
    at_cyc(s + 24); chk("cd_1", countdown, 1);
    at_cyc(s + 33); chk("cd_last_state", state, 1);
                    chk("cd_last_tick", sec_tick, 1);
    at_cyc(e);      chk("play_state", state, 2);
                    chk("play_en", play_en, 1);
                    chk("cd_0", countdown, 0);
                    chk("first_spawn", spawn_tick, 1);
                    chk("play_timer5", timer, 5);
    at_cyc(e + 5);  speed_level = 2'b10;
    at_cyc(e + 10); chk("timer_4", timer, 4);
    at_cyc(e + 20); chk("timer_3", timer, 3);
    at_cyc(e + 40); chk("timer_1", timer, 1);
    at_cyc(e + 49); chk("pre_over_state", state, 2);
    at_cyc(e + 50); chk("over_state", state, 4);
                    chk("over_timer", timer, 0);
                    chk("round_done_pulse", round_done, 1);
                    chk("high_score_42", high_score, 42);
                    chk("over_play_en", play_en, 0);
    at_cyc(e + 51); chk("round_done_clear", round_done, 0);

    // Round 2: restart from OVER, hit at count 19, ignored hits and start press, low score.
    at_cyc(e + 60);
    s = cyc;
    e = s + 34;
    score       = 14'd7;
    speed_level = 2'b00;
    start_n     = 1'b0;
    spawn_q.push_back(e);
    spawn_q.push_back(e + 20);
    spawn_q.push_back(e + 40);
    done_q.push_back(e + 50);
    at_cyc(s + 4);  chk("restart_state", state, 1);
                    chk("restart_timer", timer, 5);
    at_cyc(s + 6);  start_n = 1'b1;
    at_cyc(s + 10); hit_pulse = 1'b1;
    at_cyc(s + 11); hit_pulse = 1'b0;
    at_cyc(e);      chk("r2_play", state, 2);
    at_cyc(e + 19); hit_pulse = 1'b1;
    at_cyc(e + 20); hit_pulse = 1'b0;
                    chk("hit_expiry_spawn", spawn_tick, 1);
    at_cyc(e + 21); chk("hit_expiry_single", spawn_tick, 0);
    at_cyc(e + 25); start_n = 1'b0;
    at_cyc(e + 30); chk("start_ignored_play", state, 2);
    at_cyc(e + 31); start_n = 1'b1;
    at_cyc(e + 45); hit_pulse = 1'b1;
                    spawn_q.push_back(e + 46);
    at_cyc(e + 46); hit_pulse = 1'b0;
    at_cyc(e + 50); chk("r2_over", state, 4);
                    chk("high_score_kept", high_score, 42);
    at_cyc(e + 55); hit_pulse = 1'b1;
    at_cyc(e + 56); hit_pulse = 1'b0;

    // Round 3: pause at timer 3 for 100 cycles, then a pause press on the final tick.
    at_cyc(e + 60);
    s = cyc;
    e = s + 34;
    score   = 14'd30;
    start_n = 1'b0;
    spawn_q.push_back(e);
    spawn_q.push_back(e + 20);
    spawn_q.push_back(e + PauseShift + 40);
    done_q.push_back(e + PauseShift + 50);
    at_cyc(s + 6);  start_n = 1'b1;
    at_cyc(e + 20); chk("r3_timer_3", timer, 3);
    at_cyc(e + 22); pause_n = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    at_cyc(e + 26); chk("paused_state", state, 3);
    at_cyc(e + 30); pause_n = 1'b1;
    at_cyc(e + 60); chk("paused_hold_state", state, 3);
                    chk("paused_timer", timer, 3);
                    chk("paused_play_en", play_en, 0);
                    chk("paused_sec_tick", sec_tick, 0);
    at_cyc(e + 122); pause_n = 1'b0;
    at_cyc(e + 126); chk("resumed_state", state, 2);
                     chk("resumed_timer", timer, 3);
    at_cyc(e + 127); pause_n = 1'b1;
`else
    at_cyc(e + 26); chk("pause_ignored_state", state, 2);
    at_cyc(e + 30); pause_n = 1'b1;
`endif
    at_cyc(e + PauseShift + 30); chk("r3_timer_2", timer, 2);
    at_cyc(e + PauseShift + 40); chk("r3_timer_1", timer, 1);
    at_cyc(e + PauseShift + 46); pause_n = 1'b0;
    at_cyc(e + PauseShift + 50); chk("final_tick_over", state, 4);
                                 chk("r3_timer_0", timer, 0);
                                 chk("r3_high_score", high_score, 42);
    at_cyc(e + PauseShift + 52); pause_n = 1'b1;

    // Round 4: reset mid-play with score 99 aborts without round_done or high score update.
    at_cyc(e + PauseShift + 60);
    s = cyc;
    e = s + 34;
    score   = 14'd99;
    start_n = 1'b0;
    spawn_q.push_back(e);
    at_cyc(s + 6);  start_n = 1'b1;
    at_cyc(e + 10); chk("r4_play", state, 2);
    at_cyc(e + 15); rst_n = 1'b0;
    #1;
    check_reset("midreset");
    at_cyc(e + 18); rst_n = 1'b1;
    at_cyc(e + 20); chk("post_reset_state", state, 0);
                    chk("post_reset_high_score", high_score, 0);
    at_cyc(e + 70); chk("spawn_queue_drained", spawn_q.size(), 0);
                    chk("done_queue_drained", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 50_000_000, clk cycles per second; ROUND_SECONDS, default 60, round length, range 1..63; COUNTDOWN_SECONDS, default 3, pre-round countdown, range 1..3.
REQ-002 clk  in  1  system clock; all logic is single-clock on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start_n  in  1  start button, active-low, asynchronous to clk.
REQ-005 pause_n  in  1  pause button, active-low, asynchronous to clk.
REQ-006 speed_level  in  2  00 = 2 s/spawn; 01 = 1.5 s/spawn; 10 or 11 = 1 s/spawn.
REQ-007 hit_pulse  in  1  one-cycle pulse from scoring logic: target hit.
REQ-008 score  in  14  current score, 0..9999.
REQ-009 state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSED=3, OVER=4.
REQ-010 play_en  out  1  high only in PLAY.
REQ-011 timer  out  6  seconds remaining in the round.
REQ-012 countdown  out  2  seconds remaining before PLAY.
REQ-013 sec_tick  out  1  one-cycle pulse per elapsed second.
REQ-014 spawn_tick  out  1  one-cycle pulse meaning the target generator loads a new position.
REQ-015 round_done  out  1  one-cycle pulse on entry to OVER.
REQ-016 high_score  out  14  best score since reset.

Function
REQ-017 start_n and pause_n SHALL each pass a 2-flop synchronizer and a falling-edge detector; a "press" is the one-cycle pulse from the detector.
REQ-018 The state register SHALL change exactly 4 clk edges after the button input is first sampled low (2 sync + 1 edge + 1 state).
REQ-019 IDLE or OVER + start press -> COUNTDOWN; countdown=COUNTDOWN_SECONDS, timer=ROUND_SECONDS, prescaler=0, spawn counter=0.
REQ-020 Prescaler SHALL count 0..CLK_HZ-1 in COUNTDOWN and PLAY, assert sec_tick on wrap, hold its value in PAUSED, and be 0 in IDLE and OVER.
REQ-021 COUNTDOWN: sec_tick decrements countdown; the tick at countdown=1 SHALL set countdown=0 and go to PLAY.
REQ-022 spawn_tick SHALL assert in the first PLAY cycle after COUNTDOWN.
REQ-023 PLAY: spawn counter SHALL count clk cycles; at interval-1 it asserts spawn_tick and clears.
REQ-024 Spawn interval SHALL be 2*CLK_HZ, 3*CLK_HZ/2 or CLK_HZ cycles; speed_level is latched at each spawn_tick, so a speed change takes effect from the next interval.
REQ-025 hit_pulse in PLAY SHALL clear the spawn counter and give spawn_tick the next cycle; hit_pulse outside PLAY is ignored.
REQ-026 A hit_pulse and counter expiry in the same cycle SHALL produce exactly one spawn_tick.
REQ-027 PLAY: sec_tick decrements timer; the tick at timer=1 SHALL set timer=0, enter OVER and pulse round_done.
REQ-028 On entry to OVER, high_score SHALL load score if score > high_score; high_score is otherwise unchanged.
REQ-029 PLAY + pause press -> PAUSED; PAUSED + pause press -> PLAY; PAUSED + start press -> IDLE (abort, no high_score update).
REQ-030 Timer expiry and pause press in the same cycle SHALL go to OVER, and the pause press is dropped.
REQ-031 Start presses in COUNTDOWN and PLAY, and pause presses outside PLAY and PAUSED, SHALL be ignored.
REQ-032 spawn_tick SHALL be 0 outside PLAY; spawn counter holds in PAUSED.
REQ-033 Widths: the spawn counter SHALL be $clog2(2*CLK_HZ) bits; timer and countdown SHALL never wrap below 0.

Reset
REQ-034 rst_n low SHALL force: state=IDLE, play_en=0, timer=ROUND_SECONDS, countdown=0, sec_tick=0, spawn_tick=0, round_done=0, high_score=0, synchronizers idle-high, all counters 0.
REQ-035 Reset asserted mid-round SHALL abort immediately, with no round_done and no high_score update.

Configuration
REQ-036 Macro GAME_SEQ_PAUSE_EN defined: pause_n is functional and PAUSED is reachable per REQ-029/030.
REQ-037 Macro GAME_SEQ_PAUSE_EN undefined: pause_n stays a port but is ignored, PAUSED is unreachable, and the pause synchronizer is not built.

Verification (CLK_HZ=10, ROUND_SECONDS=5, COUNTDOWN_SECONDS=3)
REQ-038 start_n low from IDLE -> state=1 after 4 edges; countdown 3,2,1,0 at 10-cycle steps; state=2 with spawn_tick in the same cycle as the 3rd tick + 1.
REQ-039 speed_level=00 in PLAY -> spawn_tick every 20 cycles; set 10 mid-interval -> one more 20-cycle gap, then 10-cycle gaps.
REQ-040 hit_pulse in the cycle spawn counter=19 -> exactly one spawn_tick, next one 20 cycles later.
REQ-041 score=42 in full round -> timer 5..0, round_done one cycle at timer 0, state=4, high_score=42; next round score=7 -> high_score stays 42.
REQ-042 Pause at timer=3, hold 100 cycles, resume -> timer/prescaler frozen then continue; pause press coincident with final tick -> state=4. With macro undefined, pause has no effect.
REQ-043 rst_n low during PLAY with score=99 -> all outputs at reset values, high_score=0, no round_done.
